// File: rtl/aluctl_mc.sv
// aluctl_mc: registered ALU control decoder with a MULT/DIV sequencer.
// Decodes aluop/funct into gout, flags undefined R-type functs, and holds
// the datapath in MUL/DIV for a fixed number of cycles with busy asserted.
module aluctl_mc #(
    parameter int GW         = 4,
    parameter int MUL_CYCLES = 8,
    parameter int DIV_CYCLES = 16,
    parameter int CW         = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    input  logic [1:0]    aluop,
    input  logic [5:0]    funct,
    output logic [GW-1:0] gout,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic          mc_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_mul;
    logic       dec_div;

    // Decode of the presented instruction; only consumed when it is accepted.
    always_comb begin
        dec_code    = 4'b0010;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (aluop)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b101010: dec_code = 4'b0111;
                    6'b000110: dec_code = 4'b0101;
                    6'b010100: dec_code = 4'b0011;
                    6'b011111: dec_code = 4'b0010;
                    6'b011000: begin
                        dec_code = 4'b1000;
                        dec_mul  = 1'b1;
                    end
                    6'b011010: begin
                        dec_code = 4'b1001;
                        dec_div  = 1'b1;
                    end
                    default: begin
                        dec_code    = 4'b0010;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Sequencer: state, step counter and all registered outputs.
    // busy/done are registered copies of the next state so they carry no
    // combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gout    <= GW'(4'b0010);
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            mc_op   <= 1'b0;
        end else begin
            case (state)
                MUL, DIV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (valid) begin
                        gout    <= GW'(dec_code);
                        illegal <= dec_illegal;
                        if (dec_mul) begin
                            state <= MUL;
                            cnt   <= CW'(MUL_CYCLES - 1);
                            mc_op <= 1'b0;
                            busy  <= 1'b1;
                        end else if (dec_div) begin
                            state <= DIV;
                            cnt   <= CW'(DIV_CYCLES - 1);
                            mc_op <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aluctl_mc.sv
// tb_aluctl_mc: table-driven decode vectors plus hand-written MULT/DIV sequences.
module tb_aluctl_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] gout;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       mc_op;

    int applied = 0;
    int miscompares = 0;

    aluctl_mc #(
        .GW(4),
        .MUL_CYCLES(8),
        .DIV_CYCLES(16),
        .CW(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid(valid),
        .aluop(aluop),
        .funct(funct),
        .gout(gout),
        .busy(busy),
        .done(done),
        .illegal(illegal),
        .mc_op(mc_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] g;
        logic       ill;
    } vec_t;

    vec_t vt[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
        valid = v;
        aluop = op;
        funct = fn;
    endtask

    initial begin
        logic saw_done;

        vt[0]  = '{1'b1, 2'b00, 6'b000000, 4'b0010, 1'b0};
        vt[1]  = '{1'b1, 2'b01, 6'b100101, 4'b0110, 1'b0};
        vt[2]  = '{1'b1, 2'b11, 6'b000000, 4'b0001, 1'b0};
        vt[3]  = '{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0};
        vt[4]  = '{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0};
        vt[5]  = '{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0};
        vt[6]  = '{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0};
        vt[7]  = '{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0};
        vt[8]  = '{1'b1, 2'b10, 6'b000110, 4'b0101, 1'b0};
        vt[9]  = '{1'b1, 2'b10, 6'b010100, 4'b0011, 1'b0};
        vt[10] = '{1'b1, 2'b10, 6'b011111, 4'b0010, 1'b0};
        vt[11] = '{1'b1, 2'b10, 6'b111111, 4'b0010, 1'b1};
        vt[12] = '{1'b0, 2'b10, 6'b100100, 4'b0010, 1'b1};
        vt[13] = '{1'b1, 2'b00, 6'b011000, 4'b0010, 1'b0};
        vt[14] = '{1'b1, 2'b10, 6'b000000, 4'b0010, 1'b1};
        vt[15] = '{1'b1, 2'b11, 6'b111111, 4'b0001, 1'b0};
        vt[16] = '{1'b1, 2'b01, 6'b011010, 4'b0110, 1'b0};

        // Reset with random inputs
        rst_n = 1'b0;
        drive(1'b1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        step();
        drive(1'b1, 2'b10, 6'b011000);
        step();
        check("rst_gout", 32'(gout), 32'h2);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        check("rst_mc_op", 32'(mc_op), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 6'b000000);
        step();

        // Single-cycle decode table
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].v, vt[i].op, vt[i].fn);
            step();
            check($sformatf("vec%0d_gout", i), 32'(gout), 32'(vt[i].g));
            check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
            check($sformatf("vec%0d_done", i), 32'(done), 32'h0);
        end
        drive(1'b0, 2'b00, 6'b000000);
        step();

        // MULT: busy for 8 cycles, add at cycle 4 ignored, done in cycle 9
        drive(1'b1, 2'b10, 6'b011000);
        step();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul_c%0d_busy", i), 32'(busy), 32'h1);
            check($sformatf("mul_c%0d_done", i), 32'(done), 32'h0);
            check($sformatf("mul_c%0d_gout", i), 32'(gout), 32'h8);
            check($sformatf("mul_c%0d_mc_op", i), 32'(mc_op), 32'h0);
            if (i == 4) drive(1'b1, 2'b10, 6'b100000);
            else drive(1'b0, 2'b00, 6'b000000);
            step();
        end
        check("mul_done", 32'(done), 32'h1);
        check("mul_done_busy", 32'(busy), 32'h0);
        check("mul_done_gout", 32'(gout), 32'h8);
        check("mul_done_mc_op", 32'(mc_op), 32'h0);
        step();
        check("mul_after_done", 32'(done), 32'h0);
        check("mul_after_busy", 32'(busy), 32'h0);
        check("mul_after_gout", 32'(gout), 32'h8);

        // DIV then add issued in the DONE cycle
        drive(1'b1, 2'b10, 6'b011010);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("div_c%0d_busy", i), 32'(busy), 32'h1);
            check($sformatf("div_c%0d_gout", i), 32'(gout), 32'h9);
            check($sformatf("div_c%0d_mc_op", i), 32'(mc_op), 32'h1);
            step();
        end
        check("div_done", 32'(done), 32'h1);
        check("div_done_busy", 32'(busy), 32'h0);
        check("div_done_mc_op", 32'(mc_op), 32'h1);
        drive(1'b1, 2'b10, 6'b100000);
        step();
        check("div_add_gout", 32'(gout), 32'h2);
        check("div_add_done", 32'(done), 32'h0);
        check("div_add_busy", 32'(busy), 32'h0);
        drive(1'b0, 2'b00, 6'b000000);
        step();

        // Reset during DIV: abandoned, no done pulse ever
        drive(1'b1, 2'b10, 6'b011010);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        for (int i = 1; i < 5; i++) step();
        check("divrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("divrst_gout", 32'(gout), 32'h2);
        check("divrst_busy", 32'(busy), 32'h0);
        check("divrst_done", 32'(done), 32'h0);
        check("divrst_mc_op", 32'(mc_op), 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        check("divrst_no_done", 32'(saw_done), 32'h0);

        // Back-to-back MULT, MULT held valid
        drive(1'b1, 2'b10, 6'b011000);
        step();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("bb1_c%0d_busy", i), 32'(busy), 32'h1);
            step();
        end
        check("bb1_done", 32'(done), 32'h1);
        check("bb1_done_busy", 32'(busy), 32'h0);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("bb2_c%0d_busy", i), 32'(busy), 32'h1);
            check($sformatf("bb2_c%0d_done", i), 32'(done), 32'h0);
            step();
        end
        check("bb2_done", 32'(done), 32'h1);
        check("bb2_done_busy", 32'(busy), 32'h0);
        step();
        check("bb2_idle_done", 32'(done), 32'h0);
        check("bb2_idle_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/aluctl_mc.md
# aluctl_mc

Registered, parametrised ALU control unit with a multi-cycle operation sequencer. It decodes `aluop`/`funct` into the ALU control code `gout` as the single-cycle decoder does, and extends it in three ways: an ORI path, illegal-function flagging, and iterative MULT/DIV sequencing. For MULT/DIV it holds the datapath in a multi-cycle state and asserts `busy` so the fetch/PC logic stalls. It sits between the main control unit and the ALU in the MIPS datapath.

## Interface
- `GW`, 4: width of `gout`. Must be ≥ 4. Codes are zero-extended into the upper bits.
- `MUL_CYCLES`, 8: cycles spent in the MULT state. Must be ≥ 1.
- `DIV_CYCLES`, 16: cycles spent in the DIV state. Must be ≥ 1.
- `CW`, 5: counter width. Must satisfy 2^CW > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `valid`  in  1  a new instruction is presented on `aluop`/`funct` this cycle.
- `aluop`  in  2  operation class from main control.
- `funct`  in  6  R-type function field.
- `gout`  out  GW  registered ALU control code.
- `busy`  out  1  a multi-cycle operation is in progress; pipeline must stall.
- `done`  out  1  one-cycle pulse when a multi-cycle operation completes.
- `illegal`  out  1  registered flag: last accepted R-type funct was undefined.
- `mc_op`  out  1  operation in flight: 0 = MULT, 1 = DIV. Meaningful only while `busy` or `done`.

## Operation
- Decode, used when an instruction is accepted:
  - `aluop` 00 → 0010 (add).
  - `aluop` 01 → 0110 (sub).
  - `aluop` 11 → 0001 (or, ORI).
  - `aluop` 10 (R-type):
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
    - 000110 → 0101 (srlv)
    - 010100 → 0011 (brz, pass rs)
    - 011111 → 0010 (jmadd)
    - 011000 → 1000 (mult step), starts MULT
    - 011010 → 1001 (div step), starts DIV
    - any other funct → 0010, with `illegal` set to 1.
- `illegal` is rewritten on every accepted instruction: 1 only for an undefined R-type funct, 0 otherwise.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: an instruction is accepted when `valid` is 1 and the state is IDLE or DONE. Acceptance updates `gout` and `illegal`.
- IDLE/DONE, accepted MULT: go to MUL, `cnt` = MUL_CYCLES-1, `mc_op` = 0.
- IDLE/DONE, accepted DIV: go to DIV, `cnt` = DIV_CYCLES-1, `mc_op` = 1.
- IDLE/DONE, accepted other instruction: go to IDLE.
- IDLE/DONE, `valid` = 0: go to IDLE; `gout` and `illegal` hold.
- MUL/DIV with `cnt` ≠ 0: `cnt` decrements by 1. `gout` holds the step code.
- MUL/DIV with `cnt` = 0: go to DONE.
- `valid` while in MUL/DIV is ignored. The producer must hold the instruction while `busy` is high.
- `busy` = 1 exactly in MUL and DIV.
- `done` = 1 exactly in DONE.
- DONE lasts one cycle. `gout` stays at the step code until another instruction is accepted.
- The counter never wraps. Parameter checks are the integrator's responsibility, not enforced in RTL.

## Timing
- Reset values (when `rst_n` = 0 at an edge): state IDLE, `gout` = 0010, `busy` = 0, `done` = 0, `illegal` = 0, `mc_op` = 0, `cnt` = 0.
- Reset takes priority over everything, including mid-operation. A MULT/DIV in flight is abandoned and no `done` pulse is produced.
- Decode latency is 1 cycle: `valid` at edge N gives `gout` valid after edge N.
- Multi-cycle: MULT accepted at edge N gives `busy` high after edges N … N+MUL_CYCLES-1, then `done` high for the one cycle after edge N+MUL_CYCLES. DIV is the same with DIV_CYCLES.
- Back-to-back issue: an instruction accepted in the DONE cycle proceeds with no bubble. A new MULT/DIV accepted in DONE re-enters MUL/DIV immediately, so `busy` rises the cycle after `done`.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with random inputs → `gout` = 0010, `busy` = 0, `done` = 0, `illegal` = 0.
- Single-cycle decode: sweep all `aluop` values and every defined funct → `gout` matches the decode list one cycle later, `illegal` = 0. Funct 111111 with `aluop` 10 → `gout` = 0010, `illegal` = 1.
- MULT with MUL_CYCLES = 8: `valid` at cycle 0 → `busy` high in cycles 1–8, `gout` = 1000, `mc_op` = 0, `done` pulses in cycle 9. A `valid` add issued at cycle 4 is ignored.
- DIV followed by add issued in the DONE cycle → `done` = 1 with `busy` = 0 in that cycle; `gout` = 0010 the next cycle; no bubble.
- Reset asserted in cycle 5 of a DIV → next cycle is IDLE with reset values; no `done` pulse ever appears.
- Back-to-back MULT, MULT → two `busy` windows of 8 cycles each, separated by exactly one `done` cycle.
